// File: rtl/fp_round_pipe_if.sv
// Operand/result bus of the pipelined round-to-integral unit.
// Handshake: a word moves across a port on every clock edge where valid and
// ready are both high; a producer holds valid and its payload stable until
// that edge, and ready may depend combinationally on the downstream ready.
interface fp_round_pipe_if #(
   parameter int EXP_W = 8,
   parameter int MAN_W = 15,
   parameter int TAG_W = 4
);
   localparam int WIDTH = 1 + EXP_W + MAN_W;

   logic             in_valid_i;
   logic             in_ready_o;
   logic [WIDTH-1:0] in_data_i;
   logic [1:0]       in_mode_i;
   logic [TAG_W-1:0] in_tag_i;
   logic             out_valid_o;
   logic             out_ready_i;
   logic [WIDTH-1:0] out_data_o;
   logic             out_inexact_o;
   logic [TAG_W-1:0] out_tag_o;

   // Producer of operands / consumer of results.
   modport master (
      output in_valid_i, in_data_i, in_mode_i, in_tag_i, out_ready_i,
      input  in_ready_o, out_valid_o, out_data_o, out_inexact_o, out_tag_o
   );

   // The rounding unit itself.
   modport slave (
      input  in_valid_i, in_data_i, in_mode_i, in_tag_i, out_ready_i,
      output in_ready_o, out_valid_o, out_data_o, out_inexact_o, out_tag_o
   );
endinterface

// File: rtl/fp_round_pipe.sv
// Two-stage round-to-integral unit: stage 1 classifies the operand and builds
// the fraction mask plus guard/sticky/lsb; stage 2 clears the fraction,
// applies the mode-dependent increment and registers the result.
module fp_round_pipe #(
   parameter int EXP_W = 8,
   parameter int MAN_W = 15,
   parameter int TAG_W = 4
) (
   input logic           clk_i,
   input logic           rst_i,
   fp_round_pipe_if.slave bus
);
   localparam int WIDTH = 1 + EXP_W + MAN_W;
   localparam int BIAS  = 2 ** (EXP_W - 1) - 1;
   // Smallest exponent at which every representable value is an integer.
   localparam logic [EXP_W:0]   INT_EXP  = (EXP_W + 1)'(BIAS + MAN_W);
   localparam logic [EXP_W-1:0] ONE_EXP  = EXP_W'(BIAS);
   localparam logic [EXP_W-1:0] HALF_EXP = EXP_W'(BIAS - 1);

   typedef enum logic [2:0] {
      CL_ZERO,      // zero or denormal: flushes to signed zero
      CL_SMALL,     // 0 < |x| < 1
      CL_MID,       // has both integer and fraction bits
      CL_INTEGRAL,  // no fraction bits left
      CL_SPECIAL    // inf / NaN
   } cls_t;

   // ---------------- handshake ----------------
   logic v1, v2;
   logic ready1, ready2;

   assign ready2         = !v2 || bus.out_ready_i;
   assign ready1         = !v1 || ready2;
   assign bus.in_ready_o = ready1;

   // ---------------- stage 1 decode ----------------
   logic                 in_sign;
   logic [EXP_W-1:0]     in_exp;
   logic [MAN_W-1:0]     in_man;
   logic [MAN_W:0]       in_sig;
   logic [EXP_W:0]       frac_cnt;
   logic [MAN_W-1:0]     mask_c;
   logic [MAN_W:0]       unit_c;
   logic                 guard_c, sticky_c, lsb_c, nz_c, above_half_c;
   cls_t                 cls_c;

   assign in_sign = bus.in_data_i[WIDTH-1];
   assign in_exp  = bus.in_data_i[WIDTH-2:MAN_W];
   assign in_man  = bus.in_data_i[MAN_W-1:0];
   assign in_sig  = {1'b1, in_man};

   // Classify the operand and locate its fraction bits; only meaningful for CL_MID.
   always_comb begin
      frac_cnt     = INT_EXP - {1'b0, in_exp};
      mask_c       = ~({MAN_W{1'b1}} << frac_cnt);
      unit_c       = (MAN_W + 1)'(1) << frac_cnt;
      guard_c      = |(in_sig & (unit_c >> 1));
      sticky_c     = |(in_man & (mask_c >> 1));
      lsb_c        = |(in_sig & unit_c);
      nz_c         = |(in_man & mask_c);
      above_half_c = (in_exp == HALF_EXP) && (in_man != '0);
      if (in_exp == {EXP_W{1'b1}})
         cls_c = CL_SPECIAL;
      else if (in_exp == '0)
         cls_c = CL_ZERO;
      else if ({1'b0, in_exp} >= INT_EXP)
         cls_c = CL_INTEGRAL;
      else if (in_exp < ONE_EXP)
         cls_c = CL_SMALL;
      else
         cls_c = CL_MID;
   end

   logic                     s1_sign;
   logic [EXP_W+MAN_W-1:0]   s1_expman;
   logic [1:0]               s1_mode;
   logic [TAG_W-1:0]         s1_tag;
   cls_t                     s1_cls;
   logic [MAN_W-1:0]         s1_mask;
   logic [MAN_W:0]           s1_unit;
   logic                     s1_guard, s1_sticky, s1_lsb, s1_nz, s1_above_half;

   // Stage 1 register: capture a new operand whenever the stage can move.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         v1            <= 1'b0;
         s1_sign       <= 1'b0;
         s1_expman     <= '0;
         s1_mode       <= '0;
         s1_tag        <= '0;
         s1_cls        <= CL_ZERO;
         s1_mask       <= '0;
         s1_unit       <= '0;
         s1_guard      <= 1'b0;
         s1_sticky     <= 1'b0;
         s1_lsb        <= 1'b0;
         s1_nz         <= 1'b0;
         s1_above_half <= 1'b0;
      end else if (ready1) begin
         v1 <= bus.in_valid_i;
         if (bus.in_valid_i) begin
            s1_sign       <= in_sign;
            s1_expman     <= bus.in_data_i[WIDTH-2:0];
            s1_mode       <= bus.in_mode_i;
            s1_tag        <= bus.in_tag_i;
            s1_cls        <= cls_c;
            s1_mask       <= mask_c;
            s1_unit       <= unit_c;
            s1_guard      <= guard_c;
            s1_sticky     <= sticky_c;
            s1_lsb        <= lsb_c;
            s1_nz         <= nz_c;
            s1_above_half <= above_half_c;
         end
      end
   end

   // ---------------- stage 2 compute ----------------
   logic [EXP_W+MAN_W-1:0] cleared, bumped;
   logic                   mid_inc, small_up;
   logic [WIDTH-1:0]       res_data;
   logic                   res_inexact;

   // Clear the fraction, decide the increment, and pick the result per class.
   // Adding the unit to the combined exponent/mantissa field lets a mantissa
   // carry-out roll straight into the exponent.
   always_comb begin
      cleared     = s1_expman & ~{{EXP_W{1'b0}}, s1_mask};
      bumped      = cleared + {{(EXP_W-1){1'b0}}, s1_unit};
      mid_inc     = 1'b0;
      small_up    = 1'b0;
      res_data    = {s1_sign, s1_expman};
      res_inexact = 1'b0;
      case (s1_mode)
         2'b00: begin
            mid_inc  = s1_guard & (s1_sticky | s1_lsb);
            small_up = s1_above_half;
         end
         2'b01: begin
            mid_inc  = 1'b0;
            small_up = 1'b0;
         end
         2'b10: begin
            mid_inc  = s1_sign & s1_nz;
            small_up = s1_sign;
         end
         default: begin
            mid_inc  = !s1_sign & s1_nz;
            small_up = !s1_sign;
         end
      endcase
      case (s1_cls)
         CL_ZERO: res_data = {s1_sign, {(WIDTH-1){1'b0}}};
         CL_SMALL: begin
            res_data    = {s1_sign, (small_up ? ONE_EXP : {EXP_W{1'b0}}), {MAN_W{1'b0}}};
            res_inexact = 1'b1;
         end
         CL_MID: begin
            res_data    = {s1_sign, (mid_inc ? bumped : cleared)};
            res_inexact = s1_nz;
         end
         default: res_data = {s1_sign, s1_expman};
      endcase
   end

   logic [WIDTH-1:0] s2_data;
   logic             s2_inexact;
   logic [TAG_W-1:0] s2_tag;

   // Stage 2 register: this is the output; it holds while the consumer stalls.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         v2         <= 1'b0;
         s2_data    <= '0;
         s2_inexact <= 1'b0;
         s2_tag     <= '0;
      end else if (ready2) begin
         v2 <= v1;
         if (v1) begin
            s2_data    <= res_data;
            s2_inexact <= res_inexact;
            s2_tag     <= s1_tag;
         end
      end
   end

   assign bus.out_valid_o   = v2;
   assign bus.out_data_o    = s2_data;
   assign bus.out_inexact_o = s2_inexact;
   assign bus.out_tag_o     = s2_tag;
endmodule

// File: tb/tb_fp_round_pipe.sv
// Bench for fp_round_pipe: directed vectors, backpressure, random traffic
// against an arithmetic reference model, and reset flush.
module tb_fp_round_pipe;
   localparam int EXP_W = 8;
   localparam int MAN_W = 15;
   localparam int TAG_W = 4;
   localparam int W     = 1 + EXP_W + MAN_W;
   localparam int BIAS  = 127;
   localparam int PK_W  = TAG_W + 1 + W;

   // ---------------- clock / reset ----------------
   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   fp_round_pipe_if #(.EXP_W(EXP_W), .MAN_W(MAN_W), .TAG_W(TAG_W)) bus ();

   fp_round_pipe #(.EXP_W(EXP_W), .MAN_W(MAN_W), .TAG_W(TAG_W)) dut (
      .clk_i (clk),
      .rst_i (rst),
      .bus   (bus)
   );

   int n_checks = 0;
   int n_errors = 0;
   int n_out    = 0;
   logic [PK_W-1:0] exp_q[$];

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // Reference: value = sig * 2^(e-BIAS-MAN_W); round the integer quotient by
   // the remainder, then renormalise.  Returns {inexact, word}.
   function automatic logic [W:0] ref_round(input logic [1:0] mode, input logic [W-1:0] x);
      logic s;
      int e, m, sig, f, q, rem, half, r, mag;
      logic up;
      s = x[W-1];
      e = int'(x[W-2:MAN_W]);
      m = int'(x[MAN_W-1:0]);
      if (e == 255) return {1'b0, x};
      if (e == 0) return {1'b0, s, {(W-1){1'b0}}};
      if (e >= BIAS + MAN_W) return {1'b0, x};
      if (e < BIAS) begin
         case (mode)
            2'd0:    up = (e == BIAS - 1) && (m != 0);
            2'd1:    up = 1'b0;
            2'd2:    up = s;
            default: up = !s;
         endcase
         return {1'b1, s, (up ? EXP_W'(BIAS) : EXP_W'(0)), MAN_W'(0)};
      end
      sig  = (1 << MAN_W) + m;
      f    = BIAS + MAN_W - e;
      q    = sig >> f;
      rem  = sig - (q << f);
      half = 1 << (f - 1);
      case (mode)
         2'd0:    up = (rem > half) || (rem == half && (q % 2) == 1);
         2'd1:    up = 1'b0;
         2'd2:    up = s && (rem != 0);
         default: up = !s && (rem != 0);
      endcase
      r   = q + (up ? 1 : 0);
      mag = r << f;
      if (mag == (2 << MAN_W)) return {(rem != 0), s, EXP_W'(e + 1), MAN_W'(0)};
      return {(rem != 0), s, EXP_W'(e), MAN_W'(mag - (1 << MAN_W))};
   endfunction

   // ---------------- scoreboard / monitor ----------------
   logic [W:0] mon_r;
   always @(negedge clk) begin
      if (!rst) begin
         if (bus.out_valid_o) begin
            if (exp_q.size() == 0) begin
               check("spurious_out", 64'(bus.out_valid_o), 64'd0);
            end else begin
               check("out_word", 64'({bus.out_tag_o, bus.out_inexact_o, bus.out_data_o}), 64'(exp_q[0]));
               if (bus.out_ready_i) begin
                  void'(exp_q.pop_front());
                  n_out++;
               end
            end
         end
         if (bus.in_valid_i && bus.in_ready_o) begin
            mon_r = ref_round(bus.in_mode_i, bus.in_data_i);
            exp_q.push_back({bus.in_tag_i, mon_r});
         end
      end
   end

   // ---------------- driver tasks (called at posedge+1) ----------------
   task automatic drive(input logic [1:0] mode, input logic [W-1:0] data, input logic [TAG_W-1:0] tag);
      logic accepted;
      int   guard;
      accepted = 1'b0;
      guard    = 0;
      bus.in_valid_i = 1'b1;
      bus.in_mode_i  = mode;
      bus.in_data_i  = data;
      bus.in_tag_i   = tag;
      do begin
         @(negedge clk);
         accepted = bus.in_ready_o;
         guard++;
      end while (!accepted && guard < 200);
      @(posedge clk);
      #1;
      bus.in_valid_i = 1'b0;
      if (!accepted) check("in_accept_timeout", 64'(accepted), 64'd1);
   endtask

   task automatic drain();
      int guard;
      guard = 0;
      while (exp_q.size() != 0 && guard < 500) begin
         @(negedge clk);
         guard++;
      end
      if (exp_q.size() != 0) check("drain_timeout", 64'(exp_q.size()), 64'd0);
      @(posedge clk);
      #1;
   endtask

   // Single operand with an independently written expectation and latency check.
   task automatic directed(input logic [1:0] mode, input logic [W-1:0] din,
                           input logic [W-1:0] dout, input logic inx, input logic [TAG_W-1:0] tag);
      int lat;
      drive(mode, din, tag);
      lat = 1;
      @(negedge clk);
      while (!bus.out_valid_o && lat < 10) begin
         @(negedge clk);
         lat++;
      end
      check("dir_latency", 64'(lat), 64'd2);
      check("dir_result", 64'({bus.out_inexact_o, bus.out_data_o}), 64'({inx, dout}));
      @(posedge clk);
      #1;
   endtask

   function automatic logic [W-1:0] rand_word();
      logic [EXP_W-1:0] e;
      logic [MAN_W-1:0] m;
      int k;
      case ($urandom_range(0, 9))
         0:       e = 8'hFF;
         1:       e = 8'h00;
         2:       e = EXP_W'($urandom_range(BIAS + MAN_W, 254));
         3, 4, 5: e = EXP_W'($urandom_range(BIAS, BIAS + MAN_W - 1));
         6, 7:    e = EXP_W'($urandom_range(BIAS - 3, BIAS - 1));
         default: e = EXP_W'($urandom_range(1, 200));
      endcase
      m = MAN_W'($urandom);
      if ($urandom_range(0, 2) == 0) begin
         k = $urandom_range(1, MAN_W);
         m = m & ~MAN_W'((1 << k) - 1);
         if ($urandom_range(0, 1) == 1) m = m | MAN_W'(1 << (k - 1));
      end
      return {1'($urandom), e, m};
   endfunction

   typedef struct packed {
      logic [1:0]   mode;
      logic [W-1:0] din;
      logic [W-1:0] dout;
      logic         inx;
   } vec_t;

   vec_t vecs[$];
   logic [W-1:0] bp_ops[4];
   logic rand_phase = 1'b0;

   // ---------------- main sequence ----------------
   initial begin
      int idx, base, guard;
      bus.in_valid_i  = 1'b0;
      bus.in_data_i   = '0;
      bus.in_mode_i   = '0;
      bus.in_tag_i    = '0;
      bus.out_ready_i = 1'b1;

      repeat (3) @(posedge clk);
      @(negedge clk);
      check("rst_out_valid", 64'(bus.out_valid_o), 64'd0);
      check("rst_out_data", 64'(bus.out_data_o), 64'd0);
      check("rst_out_inexact", 64'(bus.out_inexact_o), 64'd0);
      check("rst_out_tag", 64'(bus.out_tag_o), 64'd0);
      check("rst_in_ready", 64'(bus.in_ready_o), 64'd1);
      @(posedge clk);
      #1;
      rst = 1'b0;

      // Directed vectors.
      vecs.push_back('{2'd2, 24'hBFC000, 24'hC00000, 1'b1});
      vecs.push_back('{2'd3, 24'hBFC000, 24'hBF8000, 1'b1});
      vecs.push_back('{2'd3, 24'h3FC000, 24'h400000, 1'b1});
      vecs.push_back('{2'd0, 24'h402000, 24'h400000, 1'b1});
      vecs.push_back('{2'd0, 24'h406000, 24'h408000, 1'b1});
      vecs.push_back('{2'd0, 24'h3F0000, 24'h000000, 1'b1});
      vecs.push_back('{2'd0, 24'h3F4000, 24'h3F8000, 1'b1});
      vecs.push_back('{2'd2, 24'hBE8000, 24'hBF8000, 1'b1});
      vecs.push_back('{2'd1, 24'hBE8000, 24'h800000, 1'b1});
      vecs.push_back('{2'd3, 24'hBE8000, 24'h800000, 1'b1});
      vecs.push_back('{2'd3, 24'h3FFFFF, 24'h400000, 1'b1});
      vecs.push_back('{2'd0, 24'h400000, 24'h400000, 1'b0});
      vecs.push_back('{2'd0, 24'h7F8000, 24'h7F8000, 1'b0});
      vecs.push_back('{2'd2, 24'h7FC001, 24'h7FC001, 1'b0});
      vecs.push_back('{2'd3, 24'h4B0000, 24'h4B0000, 1'b0});
      vecs.push_back('{2'd1, 24'h000123, 24'h000000, 1'b0});
      vecs.push_back('{2'd3, 24'h800123, 24'h800000, 1'b0});
      foreach (vecs[i]) directed(vecs[i].mode, vecs[i].din, vecs[i].dout, vecs[i].inx, TAG_W'(i));

      // Backpressure: consumer stalls 3 cycles while 4 operands are offered.
      bp_ops[0] = 24'hBFC000;
      bp_ops[1] = 24'h402000;
      bp_ops[2] = 24'h406000;
      bp_ops[3] = 24'hBE8000;
      bus.out_ready_i = 1'b0;
      base = n_out;
      idx  = 0;
      for (int c = 0; c < 3; c++) begin
         bus.in_valid_i = 1'b1;
         bus.in_mode_i  = 2'd2;
         bus.in_data_i  = bp_ops[idx];
         bus.in_tag_i   = TAG_W'(idx + 1);
         @(negedge clk);
         if (bus.in_ready_o) idx++;
         @(posedge clk);
         #1;
      end
      @(negedge clk);
      check("bp_accepted", 64'(idx), 64'd2);
      check("bp_in_ready_low", 64'(bus.in_ready_o), 64'd0);
      check("bp_out_data_held", 64'(bus.out_data_o), 64'hC00000);
      @(posedge clk);
      #1;
      bus.out_ready_i = 1'b1;
      guard = 0;
      while (idx < 4 && guard < 50) begin
         bus.in_valid_i = 1'b1;
         bus.in_mode_i  = 2'd2;
         bus.in_data_i  = bp_ops[idx];
         bus.in_tag_i   = TAG_W'(idx + 1);
         @(negedge clk);
         if (bus.in_ready_o) idx++;
         @(posedge clk);
         #1;
         guard++;
      end
      bus.in_valid_i = 1'b0;
      drain();
      check("bp_out_count", 64'(n_out - base), 64'd4);

      // Random traffic with random consumer stalls.
      rand_phase = 1'b1;
      fork
         begin
            while (rand_phase) begin
               @(posedge clk);
               #1;
               bus.out_ready_i = ($urandom_range(0, 3) != 0);
            end
         end
      join_none
      base = n_out;
      for (int n = 0; n < 1500; n++) begin
         drive(2'($urandom_range(0, 3)), rand_word(), TAG_W'($urandom));
         repeat ($urandom_range(0, 3) == 0 ? 1 : 0) begin
            @(posedge clk);
            #1;
         end
      end
      rand_phase = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      bus.out_ready_i = 1'b1;
      drain();
      check("rand_out_count", 64'(n_out - base), 64'd1500);

      // Reset with two operands in flight.
      bus.in_valid_i = 1'b1;
      bus.in_mode_i  = 2'd0;
      bus.in_data_i  = 24'h406000;
      bus.in_tag_i   = 4'd5;
      @(posedge clk);
      #1;
      bus.in_data_i  = 24'h402000;
      bus.in_tag_i   = 4'd6;
      @(posedge clk);
      #1;
      bus.in_valid_i = 1'b0;
      rst = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      exp_q.delete();
      @(negedge clk);
      check("flush_out_valid", 64'(bus.out_valid_o), 64'd0);
      check("flush_out_data", 64'(bus.out_data_o), 64'd0);
      @(posedge clk);
      #1;
      bus.in_valid_i = 1'b1;
      bus.in_mode_i  = 2'd3;
      bus.in_data_i  = 24'h3FC000;
      bus.in_tag_i   = 4'd7;
      @(posedge clk);
      #1;
      bus.in_valid_i = 1'b0;
      @(negedge clk);
      check("post_rst_lat1", 64'(bus.out_valid_o), 64'd0);
      @(negedge clk);
      check("post_rst_lat2", 64'(bus.out_valid_o), 64'd1);
      check("post_rst_word", 64'({bus.out_tag_o, bus.out_inexact_o, bus.out_data_o}),
            64'({4'd7, 1'b1, 24'h400000}));
      @(posedge clk);
      #1;
      drain();

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

   // Global time bound so the bench always ends on its own.
   initial begin
      #2000000;
      $display("FAIL global_timeout: got time %0t expected end before limit", $time);
      $fatal(1, "timeout");
   end
endmodule
